// File: rtl/dcnn_pkg.sv
// dcnn_pkg: shared defaults, FSM state and lane types for the DCNN datapath
package dcnn_pkg;
  localparam int N_LANE_DEF = 4;
  localparam int IN_W_DEF = 4;
  localparam int ACC_W_DEF = 12;
  localparam int N_TILE_DEF = 4;
  typedef enum logic [1:0] {IDLE, ACC, THR, OUT} acc_state_t;
  typedef logic signed [IN_W_DEF-1:0] lane_in_t;
  typedef logic signed [ACC_W_DEF-1:0] lane_acc_t;
endpackage

// File: rtl/mvm_sat_add.sv
// mvm_sat_add: sign-extend one lane result and add it to its accumulator with saturation
module mvm_sat_add
  import dcnn_pkg::*;
#(
  parameter int IN_W = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic signed [IN_W-1:0]  i_x,
  output logic signed [ACC_W-1:0] o_sum,
  output logic                    o_sat
);
  logic signed [ACC_W:0] sum;
  always_comb begin
    sum = {i_acc[ACC_W-1], i_acc} + {{(ACC_W+1-IN_W){i_x[IN_W-1]}}, i_x};
    o_sat = sum[ACC_W] ^ sum[ACC_W-1];
    // on overflow the extra sign bit tells which rail to clamp to
    o_sum = o_sat ? {sum[ACC_W], {(ACC_W-1){~sum[ACC_W]}}} : sum[ACC_W-1:0];
  end
endmodule

// File: rtl/mvm_acc_bin.sv
// mvm_acc_bin: accumulate N_TILE MVM tile results per lane, threshold them and hand off a binary vector
module mvm_acc_bin
  import dcnn_pkg::*;
#(
  parameter int N_LANE = N_LANE_DEF,
  parameter int IN_W = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int N_TILE = N_TILE_DEF
) (
  input  logic                      i_clk_acc,
  input  logic                      i_rst_acc,
  input  logic                      i_start_acc,
  input  logic                      i_ismvm,
  input  logic [N_LANE*IN_W-1:0]    i_wx_result,
  input  logic [N_LANE*ACC_W-1:0]   i_thresh,
  input  logic                      i_ready,
  output logic                      o_valid,
  output logic [N_LANE-1:0]         o_bin,
  output logic [N_LANE*ACC_W-1:0]   o_acc,
  output logic                      o_busy,
  output logic                      o_ovf
);
  localparam int CW = $clog2(N_TILE + 1);
  acc_state_t state_q, state_d;
  logic ismvm_q, cap, clr, add;
  logic [CW-1:0] tile_q, tile_d;
  logic signed [ACC_W-1:0] acc_q [N_LANE];
  logic signed [ACC_W-1:0] acc_d [N_LANE];
  logic signed [ACC_W-1:0] sum [N_LANE];
  logic [N_LANE-1:0] sat, bin_q, bin_d;
  logic [N_LANE*ACC_W-1:0] acco_q, acco_d;
  logic ovf_q, ovf_d;
  for (genvar k = 0; k < N_LANE; k++) begin : g_lane
    mvm_sat_add #(.IN_W(IN_W), .ACC_W(ACC_W)) u_add (
      .i_acc(acc_q[k]),
      .i_x(i_wx_result[k*IN_W +: IN_W]),
      .o_sum(sum[k]),
      .o_sat(sat[k])
    );
  end
  always_comb begin
    cap = ismvm_q & ~i_ismvm;
    clr = i_start_acc & ((state_q == IDLE) | (state_q == ACC));
    // a restart in ACC takes priority over a coincident capture
    add = cap & (state_q == ACC) & ~i_start_acc;
    ovf_d = ovf_q | (cap & (state_q != ACC)) | (add & (|sat));
    tile_d = clr ? '0 : add ? tile_q + CW'(1) : tile_q;
    bin_d = bin_q;
    acco_d = acco_q;
    for (int k = 0; k < N_LANE; k++) begin
      acc_d[k] = clr ? '0 : add ? sum[k] : acc_q[k];
      bin_d[k] = (state_q == THR) ? (acc_q[k] >= $signed(i_thresh[k*ACC_W +: ACC_W])) : bin_q[k];
      acco_d[k*ACC_W +: ACC_W] = (state_q == THR) ? acc_q[k] : acco_q[k*ACC_W +: ACC_W];
    end
    state_d = clr ? ACC :
              (add && tile_q == CW'(N_TILE - 1)) ? THR :
              (state_q == THR) ? OUT :
              (state_q == OUT && i_ready) ? IDLE : state_q;
  end
  always_ff @(posedge i_clk_acc or posedge i_rst_acc) begin
    if (i_rst_acc) begin
      state_q <= IDLE;
      ismvm_q <= 1'b0;
      tile_q <= '0;
      acc_q <= '{default: '0};
      bin_q <= '0;
      acco_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ismvm_q <= i_ismvm;
      tile_q <= tile_d;
      acc_q <= acc_d;
      bin_q <= bin_d;
      acco_q <= acco_d;
      ovf_q <= ovf_d;
    end
  end
  always_comb begin
    o_valid = state_q == OUT;
    o_busy = (state_q == ACC) | (state_q == THR);
    o_bin = bin_q;
    o_acc = acco_q;
    o_ovf = ovf_q;
  end
endmodule

// File: tb/tb_mvm_acc_bin.sv
// tb_mvm_acc_bin: directed checks of accumulation, thresholding, handshake, saturation and reset
module tb_mvm_acc_bin;
  logic clk = 0, rst = 1, start = 0, start6 = 0, ismvm = 0, sel6 = 0, ready = 0, ready6 = 0;
  logic [15:0] wx = '0;
  logic [47:0] thr = '0;
  logic [23:0] thr6 = '0;
  logic valid, busy, ovf, valid6, busy6, ovf6;
  logic [3:0] bin, bin6;
  logic [47:0] acc;
  logic [23:0] acc6;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  mvm_acc_bin dut (
    .i_clk_acc(clk), .i_rst_acc(rst), .i_start_acc(start), .i_ismvm(ismvm & ~sel6),
    .i_wx_result(wx), .i_thresh(thr), .i_ready(ready),
    .o_valid(valid), .o_bin(bin), .o_acc(acc), .o_busy(busy), .o_ovf(ovf)
  );

  mvm_acc_bin #(.ACC_W(6), .N_TILE(8)) dut6 (
    .i_clk_acc(clk), .i_rst_acc(rst), .i_start_acc(start6), .i_ismvm(ismvm & sel6),
    .i_wx_result(wx), .i_thresh(thr6), .i_ready(ready6),
    .o_valid(valid6), .o_bin(bin6), .o_acc(acc6), .o_busy(busy6), .o_ovf(ovf6)
  );

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [15:0] w);
    ismvm = 1;
    tick();
    ismvm = 0;
    wx = w;
    tick();
  endtask

  task automatic run_group(input logic [15:0] w);
    start = 1;
    tick();
    start = 0;
    chk("busy_after_start", busy, 1);
    repeat (4) cap(w);
    chk("latency_valid_low", valid, 0);
    tick();
  endtask

  task automatic handshake();
    ready = 1;
    tick();
    ready = 0;
    chk("valid_after_hs", valid, 0);
  endtask

  function automatic logic [15:0] p4(input int a0, input int a1, input int a2, input int a3);
    return {4'(a3), 4'(a2), 4'(a1), 4'(a0)};
  endfunction

  function automatic logic [47:0] p12(input int a0, input int a1, input int a2, input int a3);
    return {12'(a3), 12'(a2), 12'(a1), 12'(a0)};
  endfunction

  initial begin
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bin", bin, 0);
    chk("rst_acc", acc, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_acc6", acc6, 0);
    tick();
    tick();
    rst = 0;
    tick();

    thr = p12(10, 10, 10, 10);
    start = 1;
    tick();
    start = 0;
    chk("t1_busy", busy, 1);
    repeat (4) cap(p4(3, 3, 3, 3));
    chk("t1_valid_edge1", valid, 0);
    chk("t1_busy_thr", busy, 1);
    tick();
    chk("t1_valid_edge2", valid, 1);
    chk("t1_acc", acc, p12(12, 12, 12, 12));
    chk("t1_bin", bin, 4'b1111);
    chk("t1_ovf", ovf, 0);
    chk("t1_busy_out", busy, 0);
    handshake();

    thr = p12(0, 0, 0, 0);
    run_group(p4(-8, -8, -8, -8));
    chk("t2_valid", valid, 1);
    chk("t2_acc", acc, p12(-32, -32, -32, -32));
    chk("t2_bin", bin, 4'b0000);
    chk("t2_ovf", ovf, 0);
    handshake();

    thr = p12(28, -4, 1, 8);
    run_group(p4(7, -1, 0, 2));
    chk("t3_valid", valid, 1);
    chk("t3_acc", acc, p12(28, -4, 0, 8));
    chk("t3_bin", bin, 4'b1011);
    for (int i = 0; i < 5; i++) begin
      ismvm = (i % 2 == 0);
      start = (i == 2);
      tick();
      start = 0;
      chk("t3_hold_valid", valid, 1);
      chk("t3_hold_bin", bin, 4'b1011);
    end
    chk("t3_ovf", ovf, 1);
    chk("t3_hold_acc", acc, p12(28, -4, 0, 8));
    ismvm = 0;
    handshake();
    tick();
    chk("t3_idle_busy", busy, 0);

    thr = p12(4, 4, 4, 4);
    start = 1;
    tick();
    start = 0;
    repeat (2) cap(p4(3, 3, 3, 3));
    ismvm = 1;
    tick();
    ismvm = 0;
    wx = p4(5, 5, 5, 5);
    start = 1;
    tick();
    start = 0;
    repeat (4) cap(p4(1, 1, 1, 1));
    chk("t4_valid_edge1", valid, 0);
    tick();
    chk("t4_valid", valid, 1);
    chk("t4_acc", acc, p12(4, 4, 4, 4));
    chk("t4_bin", bin, 4'b1111);
    handshake();

    sel6 = 1;
    thr6 = {4{6'd30}};
    start6 = 1;
    tick();
    start6 = 0;
    repeat (4) cap(p4(7, 7, 7, 7));
    chk("t5_ovf6_early", ovf6, 0);
    repeat (4) cap(p4(7, 7, 7, 7));
    chk("t5_valid6_edge1", valid6, 0);
    chk("t5_busy6", busy6, 1);
    tick();
    chk("t5_valid6", valid6, 1);
    chk("t5_acc6", acc6, {4{6'h1F}});
    chk("t5_bin6", bin6, 4'b1111);
    chk("t5_ovf6", ovf6, 1);
    ready6 = 1;
    tick();
    ready6 = 0;
    thr6 = {4{6'h21}};
    start6 = 1;
    tick();
    start6 = 0;
    repeat (8) cap(p4(-8, -8, -8, -8));
    tick();
    chk("t5n_valid6", valid6, 1);
    chk("t5n_acc6", acc6, {4{6'h20}});
    chk("t5n_bin6", bin6, 4'b0000);
    ready6 = 1;
    tick();
    ready6 = 0;
    chk("t5n_valid6_hs", valid6, 0);
    sel6 = 0;

    thr = p12(8, 8, 8, 8);
    start = 1;
    tick();
    start = 0;
    cap(p4(2, 2, 2, 2));
    chk("t6_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ovf", ovf, 0);
    chk("t6_rst_valid", valid, 0);
    chk("t6_rst_acc", acc, 0);
    #2 rst = 0;
    tick();
    run_group(p4(2, 2, 2, 2));
    chk("t6_out_valid", valid, 1);
    chk("t6_out_acc", acc, p12(8, 8, 8, 8));
    chk("t6_out_ovf", ovf, 0);
    #2 rst = 1;
    #1;
    chk("t6_rst2_valid", valid, 0);
    chk("t6_rst2_acc", acc, 0);
    chk("t6_rst2_bin", bin, 0);
    #2 rst = 0;
    tick();

    thr = p12(4, 8, -12, 1);
    run_group(p4(1, 2, -3, 0));
    chk("t7_valid", valid, 1);
    chk("t7_acc", acc, p12(4, 8, -12, 0));
    chk("t7_bin", bin, 4'b0111);
    chk("t7_ovf", ovf, 0);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mvm_acc_bin.md
Name: mvm_acc_bin

Overview:
- Downstream neighbour of the MVM stage.
- Collects successive 4-lane MVM tile results (o_wx_result, qualified by the 1->0 edge of o_ismvm) into wide per-lane accumulators over N_TILE tiles.
- Compares each lane against a per-lane batch-norm threshold and emits the binarized activation vector that feeds the next layer's x input.
- Output uses a valid/ready handshake.

Parameters:
- N_LANE, 4, number of lanes; must match the MVM lane count.
- IN_W, 4, width of each MVM lane result; two's complement.
- ACC_W, 12, accumulator and threshold width; signed; must be greater than IN_W.
- N_TILE, 4, tile results accumulated per output vector; minimum 1.

Ports:
- i_clk_acc  in  1  clock; all logic is rising-edge.
- i_rst_acc  in  1  reset; asynchronous, active-high.
- i_start_acc  in  1  one-cycle pulse; clears the accumulators and begins a new output group.
- i_ismvm  in  1  MVM busy flag; a 1->0 transition marks i_wx_result as valid.
- i_wx_result  in  N_LANE x IN_W  MVM lane results; signed.
- i_thresh  in  N_LANE x ACC_W  per-lane threshold; signed; sampled in the THR state.
- i_ready  in  1  downstream accepts the output.
- o_valid  out  1  o_bin and o_acc are valid.
- o_bin  out  N_LANE  binarized activation; bit k = (acc[k] >= thresh[k]).
- o_acc  out  N_LANE x ACC_W  final accumulator values, for debug and verification.
- o_busy  out  1  high in the ACC and THR states.
- o_ovf  out  1  sticky flag: a capture was ignored, or a lane saturated.

Behaviour:
- Reset: state = IDLE; all accumulators and the tile counter = 0; ismvm_d = 0. Every output is 0: o_valid, o_bin, o_acc, o_busy, o_ovf.
- Capture event: cap = ismvm_d & ~i_ismvm, where ismvm_d is i_ismvm registered one cycle. i_wx_result is sampled in the same cycle cap is high.
- IDLE:
  - i_start_acc -> clear accumulators and tile count; go to ACC.
  - cap is ignored and sets o_ovf.
- ACC:
  - On cap: acc[k] <= sat(acc[k] + sext(i_wx_result[k])), and tile_cnt increments.
  - When cap arrives with tile_cnt == N_TILE-1, go to THR on that same edge.
  - i_start_acc in ACC restarts the group: clear accumulators, tile_cnt = 0, stay in ACC. If cap and start coincide, start wins and the cap is dropped (o_ovf is not set).
- THR (exactly 1 cycle):
  - Register o_bin[k] = (acc[k] >= i_thresh[k]), signed compare.
  - Register o_acc = acc.
  - Go to OUT.
  - cap in THR is ignored and sets o_ovf.
- OUT:
  - o_valid = 1. o_bin and o_acc are held stable until the handshake completes.
  - i_ready = 1 -> handshake completes; o_valid clears on that edge; go to IDLE.
  - i_ready low -> hold indefinitely.
  - cap in OUT is ignored and sets o_ovf.
  - i_start_acc in OUT is ignored until the handshake completes.
- Latency: o_valid rises 2 clock edges after the edge that sampled the final cap.
- Arithmetic:
  - sext sign-extends IN_W bits to ACC_W bits.
  - Addition saturates at +2^(ACC_W-1)-1 and -2^(ACC_W-1). Any lane saturating sets o_ovf.
- o_ovf clears only on reset.
- Reset asserted mid-operation: immediately returns to reset values; any partial group is discarded.
- o_busy = (state == ACC) | (state == THR).

Decomposition:
- Package dcnn_pkg holds:
  - N_LANE, IN_W and ACC_W defaults;
  - the typedef acc_state_t {IDLE, ACC, THR, OUT};
  - the lane typedefs lane_in_t = logic signed [IN_W-1:0] and lane_acc_t = logic signed [ACC_W-1:0].
- Sub-module mvm_sat_add: a per-lane combinational sign-extend plus saturating add, with a sat flag output. It is instantiated N_LANE times; the FSM and registers stay in the top.

Test Plan:
- Defaults; start; 4 caps with all lanes = 4'sd3; thresh = 10 on all lanes -> o_acc = 12 on all lanes; o_bin = 4'b1111; o_valid 2 edges after the 4th cap.
- 4 caps with all lanes = 4'b1000 (-8); thresh = 0 -> o_acc = -32; o_bin = 0000. Mixed lanes {+7, -1, 0, +2} x4 with thresh {28, -4, 1, 8} -> o_acc = {28, -4, 0, 8}; o_bin = {1, 1, 0, 1} (lane order 0..3).
- ACC_W=6, N_TILE=8, all lanes = +7 x8 -> o_acc = 31 (saturated); o_ovf = 1. Repeat with -8 -> o_acc = -32.
- Hold i_ready = 0 for 5 cycles in OUT while pulsing i_ismvm 1->0 -> o_valid stays 1; o_bin is stable; o_ovf = 1. Then i_ready = 1 -> o_valid drops next edge; state returns to IDLE.
- Start, 2 caps of 3, then i_start_acc, then 4 caps of 1 -> o_acc = 4 (earlier group discarded). Cap and start in the same cycle -> the cap is dropped.
- Assert i_rst_acc asynchronously mid-ACC and mid-OUT -> all outputs are 0 immediately, without waiting for a clock edge. After release, a full group completes normally.
